// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit owning HI/LO
// Optional feature macro: MDU_DIV0_HOLD_EN (divide by zero keeps prior HI/LO)
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDUOp,
  input  logic        start,
  input  logic        mt_we,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rdata
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] count;
  logic [31:0]   hi_n, lo_n;
  logic          launch, finish, mt_lo, mt_hi;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        b_safe, a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [31:0]        hi_c, lo_c;
  logic               div0;

  assign prod_s = $signed(A) * $signed(B);
  assign prod_u = {32'b0, A} * {32'b0, B};
  assign div0   = (B == 32'd0);
  assign b_safe = div0 ? 32'd1 : B;

  // Signed divide through magnitudes so 0x80000000 / -1 needs no special case
  assign a_mag = A[31] ? (~A + 32'd1) : A;
  assign b_mag = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (A[31] ^ b_safe[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = A[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u   = A / b_safe;
  assign r_u   = A % b_safe;

  always_comb begin
    hi_c = 32'd0;
    lo_c = 32'd0;
    case (MDUOp[1:0])
      2'd0: begin hi_c = prod_s[63:32]; lo_c = prod_s[31:0]; end
      2'd1: begin hi_c = prod_u[63:32]; lo_c = prod_u[31:0]; end
      2'd2: begin hi_c = r_s; lo_c = q_s; end
      default: begin hi_c = r_u; lo_c = q_u; end
    endcase
    if (MDUOp[1] && div0) begin
      hi_c = A;
      lo_c = 32'hFFFF_FFFF;
    end
  end

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    finish   = 1'b0;
    mt_lo    = 1'b0;
    mt_hi    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !MDUOp[2]) begin
          launch   = 1'b1;
          state_nx = RUN;
        end else if (mt_we && MDUOp == 3'd4) begin
          mt_lo = 1'b1;
        end else if (mt_we && MDUOp == 3'd5) begin
          mt_hi = 1'b1;
        end
      end
      default: begin
        if (count == CW'(1)) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
  end

`ifdef MDU_DIV0_HOLD_EN
  logic hold;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      count <= '0;
      hi_n  <= 32'd0;
      lo_n  <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
`ifdef MDU_DIV0_HOLD_EN
      hold  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (launch) begin
        hi_n  <= hi_c;
        lo_n  <= lo_c;
        count <= MDUOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        busy  <= 1'b1;
`ifdef MDU_DIV0_HOLD_EN
        hold  <= MDUOp[1] && div0;
`endif
      end else if (state == RUN) begin
        count <= count - CW'(1);
      end
      if (finish) begin
        busy <= 1'b0;
`ifdef MDU_DIV0_HOLD_EN
        if (!hold) begin
          HI <= hi_n;
          LO <= lo_n;
        end
`else
        HI <= hi_n;
        LO <= lo_n;
`endif
      end
      if (mt_lo) LO <= A;
      if (mt_hi) HI <= A;
    end
  end

  assign rdata = (MDUOp == 3'd7) ? HI : (MDUOp == 3'd6) ? LO : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - directed self-checking bench for mdu_unit
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  MDUOp;
  logic        start;
  logic        mt_we;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;
  int n;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .start(start), .mt_we(mt_we),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    @(negedge clk);
    MDUOp = op; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; MDUOp = 3'd0; start = 1'b0; mt_we = 1'b0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    @(negedge clk); reset = 1'b0;

    launch(3'd0, 32'hFFFF_FFFE, 32'd3, n);
    check("mult_cycles", n, 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    launch(3'd1, 32'hFFFF_FFFF, 32'd2, n);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    launch(3'd2, 32'hFFFF_FFF9, 32'd2, n);
    check("div_cycles", n, 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    launch(3'd3, 32'd7, 32'd2, n);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'd0);

    @(negedge clk); MDUOp = 3'd4; A = 32'h1234; mt_we = 1'b1;
    @(posedge clk); #1; mt_we = 1'b0;
    check("mtlo_lo", LO, 32'h1234);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    MDUOp = 3'd6; #1;
    check("mflo_rdata", rdata, 32'h1234);
    @(negedge clk); MDUOp = 3'd5; A = 32'hABCD; mt_we = 1'b1;
    @(posedge clk); #1; mt_we = 1'b0;
    MDUOp = 3'd7; #1;
    check("mfhi_rdata", rdata, 32'hABCD);
    MDUOp = 3'd0; #1;
    check("rdata_other", rdata, 32'd0);

    @(negedge clk); mt_we = 1'b1;
    launch(3'd0, 32'd3, 32'd4, n);
    mt_we = 1'b0;
    check("start_mt_lo", LO, 32'd12);
    check("start_mt_hi", HI, 32'd0);

    launch(3'd3, 32'h55, 32'd0, n);
    check("div0_cycles", n, 32'd10);
`ifdef MDU_DIV0_HOLD_EN
    check("div0_lo", LO, 32'd12);
    check("div0_hi", HI, 32'd0);
`else
    check("div0_lo", LO, 32'hFFFF_FFFF);
    check("div0_hi", HI, 32'h55);
`endif

    @(negedge clk); MDUOp = 3'd2; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    check("abort_no_late_lo", LO, 32'd0);

    @(negedge clk); MDUOp = 3'd0; A = 32'd5; B = 32'd6; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 1;
    @(negedge clk); MDUOp = 3'd3; A = 32'd9; B = 32'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n++;
    @(negedge clk); MDUOp = 3'd4; A = 32'hDEAD; mt_we = 1'b1;
    @(posedge clk); #1; mt_we = 1'b0;
    n++;
    MDUOp = 3'd6; #1;
    check("busy_rdata_pre", rdata, 32'd0);
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      if (busy === 1'b1) n++;
    end
    check("stray_cycles", n, 32'd5);
    check("stray_lo", LO, 32'd30);
    check("stray_hi", HI, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Consumes the decoder's MDUOp, MDU_start and mt/mf classification, and owns the HI/LO registers.
- Exposes a busy flag so the hazard unit can stall md/mt/mf instructions that arrive while an operation is in flight.
- Returns mfhi/mflo read data to the EX-stage write-back mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- MDUOp  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mtlo, 5 mthi, 6 mflo, 7 mfhi
- start  input  1  one-cycle launch strobe; valid only with MDUOp 0–3
- mt_we  input  1  write strobe for mtlo/mthi; valid only with MDUOp 4–5
- A  input  32  rs operand (multiplicand / dividend / mt data)
- B  input  32  rt operand (multiplier / divisor)
- busy  output  1  registered; high while an operation is in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register
- rdata  output  32  combinational: MDUOp==7 → HI, MDUOp==6 → LO, else 0

Behaviour:
- Reset: HI=0, LO=0, busy=0, counter=0, shadow result regs=0. Reset wins over start and mt_we in the same cycle. Reset mid-operation aborts the operation; HI/LO are not updated.
- States: IDLE, RUN.
- IDLE, start=1, op in 0–3:
  - Latch A/B and op.
  - Compute the result into shadow registers hi_n/lo_n.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- RUN: counter decrements each cycle. At the edge where the counter goes 1→0: HI←hi_n, LO←lo_n, busy←0, go to IDLE.
- Latency: start sampled at edge T; busy high for exactly N cycles (edges T..T+N); new HI/LO visible after edge T+N, same edge busy falls.
- mult: signed 64-bit product of A×B; HI=[63:32], LO=[31:0].
- multu: same as mult, unsigned.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B==0) without the macro: LO=0xFFFFFFFF, HI=A, for both div and divu.
- mt_we in IDLE, no start: op 4 → LO←A; op 5 → HI←A. Takes effect next edge; no busy.
- start and mt_we together: start wins; mt_we ignored.
- start or mt_we while busy=1: ignored; no state change. The hazard unit must stall these.
- rdata is purely combinational from current HI/LO. While busy, it returns the pre-operation value (the stall guarantees it is never consumed).
- start with MDUOp 4–7, or mt_we with MDUOp 0–3 or 6–7: ignored.

Optional Feature:
- Macro: MDU_DIV0_HOLD_EN.
- Defined: div/divu with B==0 still runs the full DIV_CYCLES busy period, but HI and LO keep their prior values at completion.
- Undefined: divide by zero writes LO=0xFFFFFFFF, HI=A, as above.

Test Plan:
1. Reset, then start op0 A=0xFFFFFFFE B=3 → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. start op1 A=0xFFFFFFFF B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
3. start op2 A=-7 (0xFFFFFFF9) B=2 → busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat with op3 A=7 B=2 → LO=3, HI=1.
4. mt_we op4 A=0x1234 → LO=0x1234 next cycle, busy stays 0. MDUOp=6 → rdata=0x1234. Then start op0 plus mt_we the same cycle → mt ignored.
5. start op3 B=0, A=0x55 → without macro LO=0xFFFFFFFF, HI=0x55. With MDU_DIV0_HOLD_EN, HI/LO unchanged; busy still lasts 10 cycles.
6. start op2, pulse reset at busy cycle 4 → busy=0, HI=LO=0 next cycle. A start pulse issued while busy is ignored, and the original result lands on schedule.
